// File: rtl/instr_fetch_pkg.sv
// Shared sequencer phase encodings and widths, used by instr_fetch and by the program sequencer FSM.
package instr_fetch_pkg;

  localparam int SEQ_STATE_W = 3;

  typedef enum logic [SEQ_STATE_W-1:0] {
    RESET_STATE = 3'd0,
    FETCH_INSTR = 3'd1,
    READ_OPS    = 3'd2,
    EXECUTE     = 3'd3,
    WRITEBACK   = 3'd4
  } seq_state_e;

endpackage

// File: rtl/instr_fetch_prgrm_stack.sv
// Return-address LIFO: push/pop take effect on the next clock edge, and top_data is combinational from the pointer.
// There is no backpressure; a push while full or a pop while empty is dropped, and the caller flags it.
module prgrm_stack #(
  parameter int PC_W        = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_data,
  output logic [PC_W-1:0] top_data,
  output logic            full,
  output logic            empty
);

  localparam int AW = $clog2(STACK_DEPTH);

  logic [PC_W-1:0] mem [STACK_DEPTH];
  logic [AW:0]     sp;
  logic [AW-1:0]   top_idx;

  // sp counts the live entries, so it needs one bit more than the index to represent "full".
  assign full     = (sp == (AW+1)'(STACK_DEPTH));
  assign empty    = (sp == '0);
  assign top_idx  = AW'(sp - (AW+1)'(1));
  assign top_data = mem[top_idx];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + (AW+1)'(1);
    end else if (pop && !empty) begin
      sp <= sp - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[sp[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Program counter, instruction register and call/return control, stepped by the external sequencer phase.
// Takes one cycle per phase: InstrReg loads at the end of FETCH_INSTR and PC updates at the end of WRITEBACK; there is no backpressure.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int PC_W        = 8,
  parameter int INSTR_W     = 16,
  parameter int STACK_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [SEQ_STATE_W-1:0] CurrentState,
  input  logic                   Jump,
  input  logic                   Call,
  input  logic                   Return,
  input  logic [PC_W-1:0]        JumpAddr,
  input  logic [INSTR_W-1:0]     ImemRdata,
  output logic [PC_W-1:0]        ImemAddr,
  output logic                   ImemRd,
  output logic [PC_W-1:0]        PC,
  output logic [INSTR_W-1:0]     InstrReg,
  output logic                   StackOvf,
  output logic                   StackUnf
);

  logic            in_fetch;
  logic            in_wb;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] pc_nxt;
  logic [PC_W-1:0] stk_top;
  logic            stk_full;
  logic            stk_empty;
  logic            stk_push;
  logic            stk_pop;
  logic            set_ovf;
  logic            set_unf;

  assign in_fetch = (CurrentState == FETCH_INSTR);
  assign in_wb    = (CurrentState == WRITEBACK);
  assign pc_inc   = PC + PC_W'(1);
  assign ImemAddr = PC;
  assign ImemRd   = in_fetch;

  // Return wins outright, so a Call alongside it neither pushes nor raises StackOvf.
  always_comb begin
    pc_nxt   = PC;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    set_ovf  = 1'b0;
    set_unf  = 1'b0;
    if (in_wb) begin
      if (Return) begin
        if (stk_empty) begin
          pc_nxt  = pc_inc;
          set_unf = 1'b1;
        end else begin
          pc_nxt  = stk_top;
          stk_pop = 1'b1;
        end
      end else if (Call) begin
        pc_nxt = JumpAddr;
        if (stk_full) begin
          set_ovf = 1'b1;
        end else begin
          stk_push = 1'b1;
        end
      end else if (Jump) begin
        pc_nxt = JumpAddr;
      end else begin
        pc_nxt = pc_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      PC       <= '0;
      InstrReg <= '0;
      StackOvf <= 1'b0;
      StackUnf <= 1'b0;
    end else begin
      PC <= pc_nxt;
      if (in_fetch) begin
        InstrReg <= ImemRdata;
      end
      if (set_ovf) begin
        StackOvf <= 1'b1;
      end
      if (set_unf) begin
        StackUnf <= 1'b1;
      end
    end
  end

  prgrm_stack #(
    .PC_W        (PC_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (pc_inc),
    .top_data  (stk_top),
    .full      (stk_full),
    .empty     (stk_empty)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: table of sequencer rounds, then a mid-WRITEBACK reset sequence.
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  logic        clk;
  logic        reset_n;
  logic [2:0]  CurrentState;
  logic        Jump;
  logic        Call;
  logic        Return;
  logic [7:0]  JumpAddr;
  logic [15:0] ImemRdata;
  logic [7:0]  ImemAddr;
  logic        ImemRd;
  logic [7:0]  PC;
  logic [15:0] InstrReg;
  logic        StackOvf;
  logic        StackUnf;

  int checks   = 0;
  int failures = 0;
  logic [7:0] prev_pc;

  instr_fetch #(
    .PC_W        (8),
    .INSTR_W     (16),
    .STACK_DEPTH (4)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .CurrentState (CurrentState),
    .Jump         (Jump),
    .Call         (Call),
    .Return       (Return),
    .JumpAddr     (JumpAddr),
    .ImemRdata    (ImemRdata),
    .ImemAddr     (ImemAddr),
    .ImemRd       (ImemRd),
    .PC           (PC),
    .InstrReg     (InstrReg),
    .StackOvf     (StackOvf),
    .StackUnf     (StackUnf)
  );

  // Instruction memory: word = address + 0x1000
  assign ImemRdata = {8'h10, ImemAddr};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       j;
    logic       c;
    logic       r;
    logic [7:0] addr;
    logic       xj;   // drive Jump=1/JumpAddr=0x77 outside WRITEBACK
    logic [7:0] pc;   // expected PC after WRITEBACK
    logic       ovf;
    logic       unf;
  } vec_t;

  localparam int NV = 21;
  vec_t tbl [NV];

  function automatic vec_t mk(logic j, logic c, logic r, logic [7:0] a, logic xj,
                              logic [7:0] pc, logic ovf, logic unf);
    vec_t v;
    v.j = j; v.c = c; v.r = r; v.addr = a; v.xj = xj;
    v.pc = pc; v.ovf = ovf; v.unf = unf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] st, input logic j, input logic c, input logic r,
                       input logic [7:0] a);
    @(negedge clk);
    CurrentState = st;
    Jump = j; Call = c; Return = r; JumpAddr = a;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_round(input vec_t v, input int idx);
    logic [15:0] exp_instr;
    exp_instr = {8'h10, prev_pc};
    drive(FETCH_INSTR, v.xj, 1'b0, 1'b0, v.xj ? 8'h77 : 8'h00);
    #1;
    chk($sformatf("v%0d fetch ImemRd", idx), ImemRd, 1'b1);
    chk($sformatf("v%0d fetch ImemAddr", idx), ImemAddr, prev_pc);
    tick();
    chk($sformatf("v%0d InstrReg", idx), InstrReg, exp_instr);
    drive(READ_OPS, v.xj, 1'b0, 1'b0, v.xj ? 8'h77 : 8'h00);
    tick();
    drive(EXECUTE, v.xj, 1'b0, 1'b0, v.xj ? 8'h77 : 8'h00);
    tick();
    chk($sformatf("v%0d PC hold pre-WB", idx), PC, prev_pc);
    chk($sformatf("v%0d ImemRd low", idx), ImemRd, 1'b0);
    drive(WRITEBACK, v.j, v.c, v.r, v.addr);
    tick();
    chk($sformatf("v%0d PC", idx), PC, v.pc);
    chk($sformatf("v%0d StackOvf", idx), StackOvf, v.ovf);
    chk($sformatf("v%0d StackUnf", idx), StackUnf, v.unf);
    chk($sformatf("v%0d InstrReg hold", idx), InstrReg, exp_instr);
    prev_pc = v.pc;
  endtask

  initial begin
    //           j     c     r     addr   xj    pc     ovf   unf
    tbl[0]  = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h01, 1'b0, 1'b0);
    tbl[1]  = mk(1'b1, 1'b0, 1'b0, 8'h10, 1'b0, 8'h10, 1'b0, 1'b0);
    tbl[2]  = mk(1'b0, 1'b1, 1'b0, 8'h40, 1'b0, 8'h40, 1'b0, 1'b0);
    tbl[3]  = mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h11, 1'b0, 1'b0);
    tbl[4]  = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h12, 1'b0, 1'b0);
    tbl[5]  = mk(1'b1, 1'b0, 1'b0, 8'hFF, 1'b0, 8'hFF, 1'b0, 1'b0);
    tbl[6]  = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0);
    tbl[7]  = mk(1'b0, 1'b1, 1'b0, 8'h20, 1'b0, 8'h20, 1'b0, 1'b0);
    tbl[8]  = mk(1'b0, 1'b1, 1'b0, 8'h30, 1'b0, 8'h30, 1'b0, 1'b0);
    tbl[9]  = mk(1'b0, 1'b1, 1'b0, 8'h40, 1'b0, 8'h40, 1'b0, 1'b0);
    tbl[10] = mk(1'b0, 1'b1, 1'b0, 8'h50, 1'b0, 8'h50, 1'b0, 1'b0);
    tbl[11] = mk(1'b0, 1'b1, 1'b0, 8'h60, 1'b0, 8'h60, 1'b1, 1'b0);
    tbl[12] = mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h41, 1'b1, 1'b0);
    tbl[13] = mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h31, 1'b1, 1'b0);
    tbl[14] = mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h21, 1'b1, 1'b0);
    tbl[15] = mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h01, 1'b1, 1'b0);
    tbl[16] = mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h02, 1'b1, 1'b1);
    tbl[17] = mk(1'b1, 1'b0, 1'b0, 8'h21, 1'b0, 8'h21, 1'b1, 1'b1);
    tbl[18] = mk(1'b0, 1'b1, 1'b0, 8'h90, 1'b0, 8'h90, 1'b1, 1'b1);
    tbl[19] = mk(1'b1, 1'b1, 1'b1, 8'hC0, 1'b0, 8'h22, 1'b1, 1'b1);
    tbl[20] = mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h23, 1'b1, 1'b1);

    reset_n = 1'b1;
    CurrentState = RESET_STATE;
    Jump = 1'b0; Call = 1'b0; Return = 1'b0; JumpAddr = 8'h00;
    #1 reset_n = 1'b0;
    tick();
    tick();
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    chk("reset PC", PC, 8'h00);
    chk("reset InstrReg", InstrReg, 16'h0000);
    chk("reset StackOvf", StackOvf, 1'b0);
    chk("reset StackUnf", StackUnf, 1'b0);
    chk("reset ImemRd", ImemRd, 1'b0);

    prev_pc = 8'h00;
    for (int i = 0; i < NV; i++) begin
      run_round(tbl[i], i);
    end

    // Reset asserted in the middle of a WRITEBACK cycle carrying a Jump
    drive(WRITEBACK, 1'b1, 1'b0, 1'b0, 8'h55);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst PC async", PC, 8'h00);
    chk("midrst InstrReg async", InstrReg, 16'h0000);
    chk("midrst StackOvf async", StackOvf, 1'b0);
    chk("midrst StackUnf async", StackUnf, 1'b0);
    tick();
    chk("midrst PC held", PC, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    CurrentState = RESET_STATE;
    tick();
    chk("post-rst PC no jump", PC, 8'h00);
    prev_pc = 8'h00;
    run_round(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h01, 1'b0, 1'b0), 99);
    // Unused encodings hold all state
    drive(3'd6, 1'b1, 1'b1, 1'b0, 8'h33);
    tick();
    chk("enc6 PC hold", PC, 8'h01);
    chk("enc6 InstrReg hold", InstrReg, 16'h1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter PC_W, default 8, program-counter and instruction-address width.
REQ-002 SHALL have parameter INSTR_W, default 16, instruction word width.
REQ-003 SHALL have parameter STACK_DEPTH, default 4, return-stack entries, power of two, at least 2.
REQ-004 SHALL have clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have reset_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have CurrentState  input  3  sequencer phase: 0 RESET_STATE, 1 FETCH_INSTR, 2 READ_OPS, 3 EXECUTE, 4 WRITEBACK.
REQ-007 SHALL have Jump  input  1  load JumpAddr into PC at end of WRITEBACK.
REQ-008 SHALL have Call  input  1  push PC+1 and load JumpAddr at end of WRITEBACK.
REQ-009 SHALL have Return  input  1  pop return address into PC at end of WRITEBACK.
REQ-010 SHALL have JumpAddr  input  PC_W  jump or call target.
REQ-011 SHALL have ImemRdata  input  INSTR_W  instruction memory read data, combinational from ImemAddr.
REQ-012 SHALL have ImemAddr  output  PC_W  instruction memory address, equal to PC at all times.
REQ-013 SHALL have ImemRd  output  1  high exactly while CurrentState==FETCH_INSTR.
REQ-014 SHALL have PC  output  PC_W  registered program counter.
REQ-015 SHALL have InstrReg  output  INSTR_W  registered current instruction.
REQ-016 SHALL have StackOvf  output  1  sticky flag: Call issued with stack full.
REQ-017 SHALL have StackUnf  output  1  sticky flag: Return issued with stack empty.

Function
REQ-018 SHALL capture ImemRdata into InstrReg on the rising edge that ends a FETCH_INSTR cycle; InstrReg holds in all other states.
REQ-019 SHALL sample Jump, Call, Return and JumpAddr only in WRITEBACK and ignore them in every other state.
REQ-020 SHALL apply this PC-update priority at the end of WRITEBACK: Return, then Call, then Jump, then PC+1.
REQ-021 On Return with a non-empty stack, SHALL load the top entry into PC and decrement the stack pointer.
REQ-022 On Return with an empty stack, SHALL set PC to PC+1, leave the stack unchanged and set StackUnf.
REQ-023 On Call with a non-full stack, SHALL push PC+1 (mod 2^PC_W) and load JumpAddr.
REQ-024 On Call with a full stack, SHALL load JumpAddr, drop the push and set StackOvf.
REQ-025 When Return is asserted together with Call or Jump, SHALL ignore Call and Jump, with no push and no flag from Call.
REQ-026 SHALL wrap PC arithmetic modulo 2^PC_W: PC 0xFF+1 gives 0x00 at the default width.
REQ-027 SHALL leave all registers unchanged in RESET_STATE, READ_OPS, EXECUTE and the unused encodings 5-7.
REQ-028 SHALL leave PC unchanged outside WRITEBACK, so each FETCH_INSTR→WRITEBACK round advances PC at most once.

Reset
REQ-029 While reset_n is low, SHALL force PC=0, InstrReg=0, stack pointer=0, StackOvf=0 and StackUnf=0 asynchronously; stack contents need not be cleared.
REQ-030 SHALL clear StackOvf and StackUnf only by reset.
REQ-031 Reset asserted mid-cycle SHALL abort any pending WRITEBACK update; after release, the first FETCH_INSTR reads address 0.

Structure
REQ-032 SHALL take the state encodings (RESET_STATE..WRITEBACK) from the shared package also used by the program sequencer FSM; no local redefinition.
REQ-033 SHALL implement the return stack as sub-module prgrm_stack with push, pop, push data, top data, full and empty ports, parameterised by PC_W and STACK_DEPTH.
REQ-034 SHALL keep PC-update priority logic and InstrReg in instr_fetch.

Verification
REQ-035 Release reset, run the FSM with memory word = address+0x1000 -> first FETCH reads ImemAddr 0x00, InstrReg=0x1000; after WRITEBACK, PC=0x01.
REQ-036 PC=0x10, Call with JumpAddr=0x40 in WRITEBACK; next round Return -> PC=0x40, then PC=0x11; StackOvf=0, StackUnf=0.
REQ-037 Five nested Calls at STACK_DEPTH=4 -> StackOvf=1 after the 5th and PC=5th target; four Returns unwind correctly; a 5th Return sets StackUnf=1 and gives PC+1.
REQ-038 PC=0xFF with no request at WRITEBACK -> PC=0x00; Jump asserted during EXECUTE only -> no effect.
REQ-039 Return, Call and Jump asserted together with stack entry 0x22 -> PC=0x22, stack depth decreases by one, no push.
REQ-040 Assert reset_n low during WRITEBACK with Jump set -> PC=0, flags=0 immediately; no jump after release.
